mult_error_sweep_ctrl: RTL and testbench
========================================

Name: mult_error_sweep_ctrl

Overview:
- Sequencer for the approximate-multiplier error characterisation datapath.
- Sweeps operand pairs (A,B) over the full N-bit space with a programmable stride and drives them into an external exact/approx comparator instance.
- Samples that instance's absolute Error output and accumulates statistics: error sum, maximum error with its operand pair, nonzero-error count and pair count.
- Sits between the board-level start/readout logic (buttons, LEDs, 7-seg) and the comparator.

Parameters:
- N, 8, operand width; must match the comparator instance.
- SUM_W, 4*N, width of the error-sum accumulator. Holds the worst case (2^(2N) pairs × error < 2^(2N)).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level sampled each clk; launches a sweep when the FSM is in IDLE.
- abort  in  1  terminates a sweep in progress.
- stride  in  N  operand increment, sampled on the accepted start. 0 is treated as 1.
- OpA  out  N  operand A driven to the comparator; registered.
- OpB  out  N  operand B driven to the comparator; registered.
- Error  in  2N  |Exact−Approx| from the comparator; combinational in OpA/OpB.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when statistics are final.
- ErrSum  out  SUM_W  sum of Error over all issued pairs.
- ErrMax  out  2N  largest Error seen.
- MaxA  out  N  OpA of the first pair reaching ErrMax.
- MaxB  out  N  OpB of the first pair reaching ErrMax.
- NonZeroCnt  out  2N+1  number of pairs with Error≠0.
- PairCnt  out  2N+1  number of pairs accumulated.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: OpA, OpB, busy, done, ErrSum, ErrMax, MaxA, MaxB, NonZeroCnt, PairCnt. Pipeline valid flag cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0 → latch stride (0→1); clear all statistics; OpA=OpB=0; go to RUN.
  - start and abort both high → abort wins; stay in IDLE.
- RUN, each cycle:
  - Capture (OpA, OpB, Error) into a one-stage pipeline register with valid=1.
  - Advance operands: nextB = OpB + stride, computed N+1 bits wide.
  - No carry → OpB = nextB.
  - Carry → OpB = 0 and OpA += stride (also N+1 bits). A carry on OpA means the last pair was just issued: go to DRAIN and leave OpA/OpB unchanged.
  - Pairs per axis = ceil(2^N / stride); P = square of that.
- Accumulate stage, on every cycle with pipeline valid=1:
  - ErrSum += Error, at SUM_W width.
  - PairCnt += 1.
  - NonZeroCnt += (Error≠0).
  - If Error > ErrMax (strictly greater): update ErrMax, MaxA, MaxB. Ties keep the earliest pair in sweep order (A-major, B-minor).
- DRAIN: the pipeline holds the last pair; valid is cleared after this cycle; go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Latency: start high in cycle 0 → pair k (k=0..P−1) presented in cycle k+1 → done=1 in cycle P+2.
- Statistics hold their values from done until the next accepted start.
- start while busy is ignored; the stride input is ignored except at an accepted start.
- abort in RUN or DRAIN:
  - Next state is IDLE, busy drops, no done pulse.
  - The pipeline entry present in the abort cycle is discarded.
  - Statistics hold partial values; OpA/OpB hold.
- abort in IDLE or DONE: no effect; the done pulse still occurs.
- Reset asserted mid-sweep: immediate return to the reset values above; no done.
- No accumulator ever overflows at default SUM_W; no saturation logic is required.

Test Plan:
- N=8, stride=1, start pulse → done at cycle 65538; PairCnt=65536, ErrSum=24920064, ErrMax=1521, MaxA=255, MaxB=255, NonZeroCnt=61056.
- stride=64 → pairs over {0,64,128,192}; PairCnt=16, ErrSum=0, ErrMax=0, MaxA=0, MaxB=0, NonZeroCnt=0; done at cycle 18.
- stride=0 → identical results to stride=1. stride=3 → PairCnt=7396 (86 values per axis), ErrMax=1521 at (255,255).
- stride=1, abort at cycle 100 → busy low at cycle 101, no done pulse, PairCnt=98. Then start again → full stride=1 results.
- start re-pulsed while busy, and start+abort together in IDLE → sweep unaffected / FSM stays IDLE; OpA/OpB checked against the sweep order every cycle by a scoreboard.
- rst_n pulled low at cycle 500 → all outputs 0 asynchronously. Release and start → correct stride=1 results.

Source files
------------

// File: rtl/mult_error_sweep_ctrl_if.sv
// Operand/error bus between the sweep sequencer and the exact/approx comparator.
interface mult_error_sweep_ctrl_if #(
  parameter int N = 8
);
  logic [N-1:0]   OpA;
  logic [N-1:0]   OpB;
  logic [2*N-1:0] Error;

  // Sequencer side: drives operands, samples the comparator's error.
  modport master (output OpA, output OpB, input Error);
  // Comparator side.
  modport slave  (input OpA, input OpB, output Error);
endinterface

// File: rtl/mult_error_sweep_ctrl.sv
// Sweep sequencer for approximate-multiplier error characterisation.
// Walks (A,B) over the operand space with a programmable stride, pipelines the
// comparator's |Exact-Approx| by one stage and accumulates error statistics.
//
// state | meaning
// IDLE  | waiting for start; statistics hold from the previous sweep
// RUN   | issuing one operand pair per cycle
// DRAIN | last pair is in the pipeline stage, accumulate it
// DONE  | one-cycle done pulse, statistics final
module mult_error_sweep_ctrl #(
  parameter int N     = 8,
  parameter int SUM_W = 4*N
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N-1:0]           stride,
  mult_error_sweep_ctrl_if.master cmp,
  output logic                   busy,
  output logic                   done,
  output logic [SUM_W-1:0]       ErrSum,
  output logic [2*N-1:0]         ErrMax,
  output logic [N-1:0]           MaxA,
  output logic [N-1:0]           MaxB,
  output logic [2*N:0]           NonZeroCnt,
  output logic [2*N:0]           PairCnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [N-1:0]   op_a, op_b;
  logic [N-1:0]   stride_q;
  logic [N-1:0]   pipe_a, pipe_b;
  logic [2*N-1:0] pipe_err;
  logic           pipe_vld;

  logic [N:0]     sum_a, sum_b;
  logic           last_pair;
  logic           accept;

  // A carry out of both axes means the pair on the bus is the final one.
  assign sum_b     = {1'b0, op_b} + {1'b0, stride_q};
  assign sum_a     = {1'b0, op_a} + {1'b0, stride_q};
  assign last_pair = sum_b[N] & sum_a[N];
  assign accept    = start & ~abort;

  assign cmp.OpA = op_a;
  assign cmp.OpB = op_b;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort beats start and terminates RUN/DRAIN without done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (last_pair) state_nxt = DRAIN;
      DRAIN:   state_nxt = abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Operand sweep (A-major, B-minor) and the one-stage error pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= {{(N-1){1'b0}}, 1'b1};
      op_a     <= '0;
      op_b     <= '0;
      pipe_a   <= '0;
      pipe_b   <= '0;
      pipe_err <= '0;
      pipe_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pipe_vld <= 1'b0;
          if (accept) begin
            stride_q <= (stride == '0) ? {{(N-1){1'b0}}, 1'b1} : stride;
            op_a     <= '0;
            op_b     <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            pipe_vld <= 1'b0;
          end else begin
            pipe_a   <= op_a;
            pipe_b   <= op_b;
            pipe_err <= cmp.Error;
            pipe_vld <= 1'b1;
            if (!sum_b[N]) begin
              op_b <= sum_b[N-1:0];
            end else if (!sum_a[N]) begin
              op_b <= '0;
              op_a <= sum_a[N-1:0];
            end
          end
        end
        default: pipe_vld <= 1'b0;
      endcase
    end
  end

  // Statistics: cleared on an accepted start, accumulated from the pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ErrSum     <= '0;
      ErrMax     <= '0;
      MaxA       <= '0;
      MaxB       <= '0;
      NonZeroCnt <= '0;
      PairCnt    <= '0;
    end else if (state == IDLE && accept) begin
      ErrSum     <= '0;
      ErrMax     <= '0;
      MaxA       <= '0;
      MaxB       <= '0;
      NonZeroCnt <= '0;
      PairCnt    <= '0;
    end else if (pipe_vld && !abort) begin
      ErrSum     <= ErrSum + {{(SUM_W-2*N){1'b0}}, pipe_err};
      PairCnt    <= PairCnt + {{(2*N){1'b0}}, 1'b1};
      NonZeroCnt <= NonZeroCnt + {{(2*N){1'b0}}, (pipe_err != '0)};
      // Strictly greater keeps the earliest pair on ties.
      if (pipe_err > ErrMax) begin
        ErrMax <= pipe_err;
        MaxA   <= pipe_a;
        MaxB   <= pipe_b;
      end
    end
  end

endmodule

// File: tb/tb_mult_error_sweep_ctrl.sv
// Bench for mult_error_sweep_ctrl with an exact-vs-truncated multiplier stub.
`timescale 1ns/1ps
module tb_mult_error_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  stride = '0;
  logic        busy, done;
  logic [31:0] ErrSum;
  logic [15:0] ErrMax;
  logic [7:0]  MaxA, MaxB;
  logic [16:0] NonZeroCnt, PairCnt;

  int n_vec = 0;
  int n_err = 0;

  mult_error_sweep_ctrl_if #(.N(8)) cmp_bus ();

  mult_error_sweep_ctrl #(.N(8), .SUM_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stride(stride),
    .cmp(cmp_bus), .busy(busy), .done(done), .ErrSum(ErrSum), .ErrMax(ErrMax),
    .MaxA(MaxA), .MaxB(MaxB), .NonZeroCnt(NonZeroCnt), .PairCnt(PairCnt)
  );

  always #5 clk = ~clk;

  // Comparator stub: approx product drops the two low bits of each operand.
  function automatic logic [15:0] approx_err(input logic [7:0] a, input logic [7:0] b);
    int exact, apx;
    exact = int'(a) * int'(b);
    apx   = int'(a & 8'hFC) * int'(b & 8'hFC);
    return 16'(exact - apx);
  endfunction

  assign cmp_bus.Error = approx_err(cmp_bus.OpA, cmp_bus.OpB);

  // Reference model: explicit pair list in sweep order plus statistics over a prefix.
  int     qa[$], qb[$];
  longint m_sum;
  int     m_max, m_maxa, m_maxb, m_nz, m_cnt;

  task automatic build_pairs(input int s);
    int se;
    se = (s == 0) ? 1 : s;
    qa.delete();
    qb.delete();
    for (int a = 0; a < 256; a += se)
      for (int b = 0; b < 256; b += se) begin
        qa.push_back(a);
        qb.push_back(b);
      end
  endtask

  task automatic model_stats(input int k);
    int e;
    m_sum = 0; m_max = 0; m_maxa = 0; m_maxb = 0; m_nz = 0; m_cnt = 0;
    for (int i = 0; i < k; i++) begin
      e = int'(approx_err(8'(qa[i]), 8'(qb[i])));
      m_sum += e;
      m_cnt++;
      if (e != 0) m_nz++;
      if (e > m_max) begin
        m_max = e; m_maxa = qa[i]; m_maxb = qb[i];
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, ".ErrSum"},     64'(ErrSum),     64'(m_sum));
    check_eq({tag, ".ErrMax"},     64'(ErrMax),     64'(m_max));
    check_eq({tag, ".MaxA"},       64'(MaxA),       64'(m_maxa));
    check_eq({tag, ".MaxB"},       64'(MaxB),       64'(m_maxb));
    check_eq({tag, ".NonZeroCnt"}, 64'(NonZeroCnt), 64'(m_nz));
    check_eq({tag, ".PairCnt"},    64'(PairCnt),    64'(m_cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".busy"},       64'(busy),       0);
    check_eq({tag, ".done"},       64'(done),       0);
    check_eq({tag, ".OpA"},        64'(cmp_bus.OpA), 0);
    check_eq({tag, ".OpB"},        64'(cmp_bus.OpB), 0);
    check_eq({tag, ".ErrSum"},     64'(ErrSum),     0);
    check_eq({tag, ".ErrMax"},     64'(ErrMax),     0);
    check_eq({tag, ".MaxA"},       64'(MaxA),       0);
    check_eq({tag, ".MaxB"},       64'(MaxB),       0);
    check_eq({tag, ".NonZeroCnt"}, 64'(NonZeroCnt), 0);
    check_eq({tag, ".PairCnt"},    64'(PairCnt),    0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sweep: start in cycle 0, pair k expected on the bus in cycle k+1,
  // done in cycle P+2. stop_kind 1 = abort in cycle stop_at, 2 = reset in cycle stop_at.
  task automatic run_sweep(input int s, input int stop_at, input int stop_kind, input bit noisy);
    int p, idx, k;
    build_pairs(s);
    p = qa.size();
    start = 1'b1; abort = 1'b0; stride = 8'(s);
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= p + 2; cyc++) begin
      idx = (cyc <= p) ? cyc - 1 : p - 1;
      check_eq("sb.OpA", 64'(cmp_bus.OpA), 64'(qa[idx]));
      check_eq("sb.OpB", 64'(cmp_bus.OpB), 64'(qb[idx]));
      check_eq("sb.busy", 64'(busy), 64'(cyc <= p + 1));
      check_eq("sb.done", 64'(done), 64'(cyc == p + 2));
      if (cyc == stop_at && stop_kind == 1) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        k = cyc - 2;
        if (k < 0) k = 0;
        model_stats(k);
        check_stats("abort");
        check_eq("abort.OpA", 64'(cmp_bus.OpA), 64'(qa[idx]));
        check_eq("abort.OpB", 64'(cmp_bus.OpB), 64'(qb[idx]));
        for (int j = 0; j < 4; j++) begin
          check_eq("abort.busy", 64'(busy), 0);
          check_eq("abort.done", 64'(done), 0);
          tick();
        end
        return;
      end
      if (cyc == stop_at && stop_kind == 2) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        tick();
        check_all_zero("midrst_held");
        rst_n = 1'b1;
        tick();
        check_eq("midrst.done", 64'(done), 0);
        return;
      end
      if (cyc == p + 2) begin
        model_stats(p);
        check_stats("final");
      end
      if (noisy && cyc < p) begin
        start  = 1'($urandom_range(0, 1));
        stride = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (cyc < p + 2) tick();
    end
    tick();
    check_eq("post.done", 64'(done), 0);
    check_eq("post.busy", 64'(busy), 0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_all_zero("idle");

    // Full stride-1 sweep against known characterisation figures.
    run_sweep(1, 0, 0, 1'b0);
    check_eq("s1.PairCnt",    64'(PairCnt),    65536);
    check_eq("s1.ErrSum",     64'(ErrSum),     24920064);
    check_eq("s1.ErrMax",     64'(ErrMax),     1521);
    check_eq("s1.MaxA",       64'(MaxA),       255);
    check_eq("s1.MaxB",       64'(MaxB),       255);
    check_eq("s1.NonZeroCnt", 64'(NonZeroCnt), 61056);

    // start+abort together in IDLE: nothing moves, statistics hold.
    start = 1'b1; abort = 1'b1; stride = 8'd5;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check_eq("sa.busy", 64'(busy), 0);
      check_eq("sa.done", 64'(done), 0);
      tick();
    end
    check_eq("sa.OpA", 64'(cmp_bus.OpA), 255);
    check_eq("sa.OpB", 64'(cmp_bus.OpB), 255);
    check_stats("sa.hold");

    run_sweep(64, 0, 0, 1'b0);
    check_eq("s64.PairCnt", 64'(PairCnt), 16);
    check_eq("s64.ErrSum",  64'(ErrSum),  0);

    // Stride 3 with start/stride noise while busy.
    run_sweep(3, 0, 0, 1'b1);
    check_eq("s3.PairCnt", 64'(PairCnt), 7396);
    check_eq("s3.ErrMax",  64'(ErrMax),  1521);
    check_eq("s3.MaxA",    64'(MaxA),    255);
    check_eq("s3.MaxB",    64'(MaxB),    255);

    // Stride 0 behaves as 1; abort in cycle 100.
    run_sweep(0, 100, 1, 1'b0);
    check_eq("ab.PairCnt", 64'(PairCnt), 98);

    for (int r = 0; r < 4; r++)
      run_sweep(int'($urandom_range(8, 255)), 0, 0, 1'b1);

    // Asynchronous reset mid-sweep, then a clean sweep.
    run_sweep(1, 500, 2, 1'b0);
    run_sweep(int'($urandom_range(16, 255)), 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
